ioctl_download_tx: RTL and testbench

- Transmitter end of the ROM download (ioctl) interface.
- Drives ioctl_download, ioctl_index, ioctl_wr, ioctl_addr and ioctl_dout, and honours the ioctl_wait back-pressure from the receiving download sink.
- Words are pulled from a valid/ready source (a buffer in SDRAM or DDR, or a test stream).
- Used for in-core ROM reloads and as the reference driver when verifying the download path of the Main core.

---
 rtl/ioctl_download_tx.sv | 176 +++++++++++++++++
 tb/tb_ioctl_download_tx.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_download_tx.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_download_tx
// Description : Transmitter end of the ROM download (ioctl) interface.
//               Pulls 16-bit words from a valid/ready source and replays them
//               to a download sink as ioctl_wr strobes on even byte
//               addresses. The sink can stall it through ioctl_wait.
// Revision    : 1.0 - initial release
// ============================================================================
module ioctl_download_tx #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 16,
  parameter int WR_GAP     = 2
) (
  input  logic                  clock,
  input  logic                  reset,

  // Transfer control
  input  logic                  start,
  input  logic [7:0]            index,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,

  // Word source
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_WIDTH-1:0] src_data,

  // Download sink
  output logic                  ioctl_download,
  output logic [7:0]            ioctl_index,
  output logic                  ioctl_wr,
  output logic [ADDR_WIDTH-1:0] ioctl_addr,
  output logic [DATA_WIDTH-1:0] ioctl_dout,
  input  logic                  ioctl_wait
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  // The gap counter is 4 bits wide, so the gap length is clamped to 1..15.
  // The counter is loaded with GAP-1 and the state exits when it reaches 0,
  // which yields exactly WR_GAP cycles spent in ST_GAP.
  localparam int         GAP_CLAMP = (WR_GAP < 1) ? 1 : ((WR_GAP > 15) ? 15 : WR_GAP);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CLAMP - 1);

  // Byte address step between consecutive words (two bytes per word).
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(2);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] remaining;   // words still to be written
  logic [3:0]            gap_cnt;     // cycles left in ST_GAP, minus one
  logic                  zero_done;   // done pulse for a zero-length request
  logic [7:0]            index_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] dout_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  // Word count is ceil(length/2). Splitting off bit 0 keeps the sum inside
  // ADDR_WIDTH bits even for the largest possible length.
  logic [ADDR_WIDTH-1:0] word_count;
  logic                  wr_fire;
  logic                  finish_fire;

  assign word_count  = {1'b0, length[ADDR_WIDTH-1:1]}
                     + {{(ADDR_WIDTH-1){1'b0}}, length[0]};

  // The strobe is gated by ioctl_wait in the same cycle, so a wait that rises
  // while the word is presented suppresses the write immediately.
  assign wr_fire     = (state == ST_WRITE)  && !ioctl_wait;
  assign finish_fire = (state == ST_FINISH) && !ioctl_wait;

  // --------------------------------------------------------------------------
  // Transfer sequencer: latches the request, walks FETCH/WRITE/GAP per word
  // and closes the transfer once the sink is no longer stalling.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      gap_cnt   <= 4'd0;
      zero_done <= 1'b0;
      index_q   <= 8'd0;
      addr_q    <= '0;
      dout_q    <= '0;
    end else begin
      zero_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              // Nothing to send: acknowledge without touching the sink.
              zero_done <= 1'b1;
            end else begin
              index_q   <= index;
              remaining <= word_count;
              addr_q    <= '0;
              state     <= ST_SETUP;
            end
          end
        end

        // One cycle with ioctl_download high before any data moves, so the
        // sink sees the index and download flag ahead of the first strobe.
        ST_SETUP: begin
          state <= ST_FETCH;
        end

        ST_FETCH: begin
          if (src_valid) begin
            dout_q <= src_data;
            state  <= ST_WRITE;
          end
        end

        // Address and count advance as the strobe leaves, so the sink sees
        // a stable address/data pair for the whole strobe cycle.
        ST_WRITE: begin
          if (!ioctl_wait) begin
            addr_q    <= addr_q + ADDR_STEP;
            remaining <= remaining - 1'b1;
            gap_cnt   <= GAP_LOAD;
            state     <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= (remaining == '0) ? ST_FINISH : ST_FETCH;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        // The sink may still be digesting the last word; hold the download
        // flag until it releases ioctl_wait.
        ST_FINISH: begin
          if (!ioctl_wait) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy           = (state != ST_IDLE);
  assign ioctl_download = (state != ST_IDLE);
  assign done           = zero_done | finish_fire;
  assign src_ready      = (state == ST_FETCH);
  assign ioctl_wr       = wr_fire;
  assign ioctl_index    = index_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_download_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ioctl_download_tx
// Description : Self-checking bench for ioctl_download_tx. Per-cycle source
//               valid and sink wait patterns are chosen up front; a timing
//               model derives every write cycle and the done cycle from them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_download_tx;

  localparam int AW     = 25;
  localparam int DW     = 16;
  localparam int WR_GAP = 2;
  localparam int MAXC   = 400;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    index = 8'd0;
  logic [AW-1:0] length = '0;
  logic          busy, done;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [DW-1:0] src_data = '0;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [DW-1:0] ioctl_dout;
  logic          ioctl_wait = 1'b0;

  always #5 clock = ~clock;

  ioctl_download_tx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_GAP(WR_GAP)) dut (
    .clock(clock), .reset(reset), .start(start), .index(index), .length(length),
    .busy(busy), .done(done), .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus patterns, indexed by cycle relative to the start cycle
  bit            valid_pat[MAXC];
  bit            wait_pat[MAXC];
  logic [DW-1:0] words[$];
  logic [DW-1:0] sent[$];
  int            reset_at;
  int            restart_at;
  logic [7:0]    restart_index;
  logic [AW-1:0] restart_length;

  // Observations
  logic          dl_log[MAXC], busy_log[MAXC], done_log[MAXC], ready_log[MAXC], wr_log[MAXC];
  logic [AW-1:0] addr_log[MAXC];
  logic [DW-1:0] dout_log[MAXC];
  logic [7:0]    idx_log[MAXC];
  int            wr_cyc[$];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            done_cyc[$];
  int            viol;
  int            last_c;

  // Model results
  int exp_wr[$];
  int exp_done;

  // Timing model: a word is taken in the first valid FETCH cycle, written in
  // the first following cycle with wait low, then WR_GAP idle cycles follow.
  function automatic void model(int len);
    int t;
    int n;
    exp_wr.delete();
    if (len == 0) begin
      exp_done = 1;
      return;
    end
    n = (len + 1) / 2;
    t = 2;
    for (int i = 0; i < n; i++) begin
      while (t < MAXC - 1 && !valid_pat[t]) t++;
      t++;
      while (t < MAXC - 1 && wait_pat[t]) t++;
      exp_wr.push_back(t);
      t += WR_GAP + 1;
    end
    while (t < MAXC - 1 && wait_pat[t]) t++;
    exp_done = t;
  endfunction

  task automatic clear_pats();
    for (int c = 0; c < MAXC; c++) begin
      valid_pat[c] = 1'b1;
      wait_pat[c]  = 1'b0;
    end
    reset_at   = -1;
    restart_at = -1;
  endtask

  task automatic load_words(int n);
    logic [DW-1:0] w;
    words.delete();
    sent.delete();
    for (int i = 0; i < n + 4; i++) begin
      w = DW'($urandom);
      words.push_back(w);
      sent.push_back(w);
    end
  endtask

  // Drives one transfer cycle by cycle and records what the DUT does.
  task automatic run_transfer(input logic [7:0] idx, input logic [AW-1:0] len);
    logic prev_wr;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); done_cyc.delete();
    viol = 0;
    prev_wr = 1'b0;
    last_c = 0;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clock);
      reset = (c == reset_at);
      start = (c == 0) || (c == restart_at);
      if (c == 0) begin
        index = idx; length = len;
      end else if (c == restart_at) begin
        index = restart_index; length = restart_length;
      end else begin
        index = 8'($urandom); length = AW'($urandom);
      end
      src_valid  = valid_pat[c] && (words.size() > 0);
      src_data   = src_valid ? words[0] : DW'($urandom);
      ioctl_wait = wait_pat[c];
      #1;
      dl_log[c] = ioctl_download; busy_log[c] = busy; done_log[c] = done;
      ready_log[c] = src_ready; wr_log[c] = ioctl_wr;
      addr_log[c] = ioctl_addr; dout_log[c] = ioctl_dout; idx_log[c] = ioctl_index;
      if (ioctl_wr) begin
        wr_cyc.push_back(c); wr_addr.push_back(ioctl_addr); wr_data.push_back(ioctl_dout);
        if (ioctl_wait || prev_wr || !ioctl_download) viol++;
      end
      prev_wr = ioctl_wr;
      if (done) done_cyc.push_back(c);
      if (src_valid && src_ready) void'(words.pop_front());
      last_c = c;
      if (done_cyc.size() > 0 && c >= done_cyc[0] + 2) break;
      if (reset_at >= 0 && c >= reset_at + 2) break;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b1; index = 8'hA5; length = AW'(10);
    src_valid = 1'b1; ioctl_wait = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_tests++;
    if ({busy, done, src_ready, ioctl_download, ioctl_wr} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {busy, done, src_ready, ioctl_download, ioctl_wr});
    end
    n_tests++;
    if (ioctl_index !== 8'd0) begin n_fail++; $display("FAIL reset_index: got %0h want 0", ioctl_index); end
    n_tests++;
    if (ioctl_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", ioctl_addr); end
    n_tests++;
    if (ioctl_dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %0h want 0", ioctl_dout); end
    @(negedge clock);
    reset = 1'b0; start = 1'b0; src_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int bad;
    int d;
    clear_pats();
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    sent  = words;
    model(8);
    run_transfer(8'h00, AW'(8));
    n_tests++;
    if (wr_cyc.size() != 4) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 4", wr_cyc.size()); end
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
      n_tests++;
      if (wr_cyc[i] != 3 + 4 * i || wr_addr[i] !== AW'(2 * i) || wr_data[i] !== sent[i]) begin
        n_fail++;
        $display("FAIL basic_wr%0d: got cyc %0d addr %0h data %0h want cyc %0d addr %0h data %0h",
                 i, wr_cyc[i], wr_addr[i], wr_data[i], 3 + 4 * i, 2 * i, sent[i]);
      end
    end
    d = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    n_tests++;
    if (done_cyc.size() != 1 || d != 18) begin
      n_fail++; $display("FAIL basic_done: got %0d pulses first at %0d want 1 at 18", done_cyc.size(), d);
    end
    bad = 0;
    for (int c = 0; c <= last_c; c++) begin
      if (dl_log[c] !== ((c >= 1 && c <= exp_done) ? 1'b1 : 1'b0)) bad++;
      if (busy_log[c] !== ((c >= 1 && c <= exp_done) ? 1'b1 : 1'b0)) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL basic_download_span: got %0d bad cycles want 0", bad); end
    n_tests++;
    if (viol != 0 || idx_log[3] !== 8'h00) begin
      n_fail++; $display("FAIL basic_protocol: got viol %0d index %0h want 0 0", viol, idx_log[3]);
    end
  endtask

  task automatic test_back_pressure();
    int bad;
    clear_pats();
    load_words(4);
    for (int c = 7; c < 17; c++) wait_pat[c] = 1'b1;
    model(8);
    run_transfer(8'h21, AW'(8));
    n_tests++;
    if (wr_cyc.size() != 4 || wr_cyc[1] != 17 || wr_addr[1] !== AW'(2)) begin
      n_fail++; $display("FAIL bp_second_wr: got n %0d cyc %0d addr %0h want 4 17 2", wr_cyc.size(), wr_cyc[1], wr_addr[1]);
    end
    for (int i = 0; i < exp_wr.size() && i < wr_cyc.size(); i++) begin
      n_tests++;
      if (wr_cyc[i] != exp_wr[i] || wr_addr[i] !== AW'(2 * i) || wr_data[i] !== sent[i]) begin
        n_fail++;
        $display("FAIL bp_wr%0d: got cyc %0d addr %0h data %0h want cyc %0d addr %0h data %0h",
                 i, wr_cyc[i], wr_addr[i], wr_data[i], exp_wr[i], 2 * i, sent[i]);
      end
    end
    bad = 0;
    for (int c = 7; c <= 17; c++) if (dout_log[c] !== sent[1] || addr_log[c] !== AW'(2)) bad++;
    n_tests++;
    if (bad != 0 || viol != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles %0d viol want 0 0", bad, viol); end
  endtask

  task automatic test_starvation();
    int bad;
    clear_pats();
    load_words(4);
    for (int c = 6; c < 11; c++) valid_pat[c] = 1'b0;
    model(8);
    run_transfer(8'h33, AW'(8));
    bad = 0;
    for (int c = 6; c < 11; c++) if (ready_log[c] !== 1'b1 || wr_log[c] !== 1'b0) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL starve_ready: got %0d bad cycles want 0", bad); end
    n_tests++;
    if (wr_cyc.size() != exp_wr.size() || viol != 0) begin
      n_fail++; $display("FAIL starve_count: got %0d writes viol %0d want %0d 0", wr_cyc.size(), viol, exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < wr_cyc.size(); i++) begin
      n_tests++;
      if (wr_cyc[i] != exp_wr[i] || wr_addr[i] !== AW'(2 * i) || wr_data[i] !== sent[i]) begin
        n_fail++;
        $display("FAIL starve_wr%0d: got cyc %0d addr %0h data %0h want cyc %0d addr %0h data %0h",
                 i, wr_cyc[i], wr_addr[i], wr_data[i], exp_wr[i], 2 * i, sent[i]);
      end
    end
  endtask

  task automatic test_edge_lengths();
    int bad;
    int d;
    clear_pats();
    load_words(2);
    run_transfer(8'h11, AW'(0));
    d = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    n_tests++;
    if (done_cyc.size() != 1 || d != 1) begin
      n_fail++; $display("FAIL len0_done: got %0d pulses first at %0d want 1 at 1", done_cyc.size(), d);
    end
    bad = 0;
    for (int c = 0; c <= last_c; c++) if (dl_log[c] !== 1'b0 || busy_log[c] !== 1'b0 || wr_log[c] !== 1'b0) bad++;
    n_tests++;
    if (bad != 0 || words.size() != 6) begin
      n_fail++; $display("FAIL len0_idle: got %0d active cycles %0d words left want 0 6", bad, words.size());
    end
    clear_pats();
    load_words(3);
    model(5);
    run_transfer(8'h55, AW'(5));
    n_tests++;
    if (wr_cyc.size() != 3) begin n_fail++; $display("FAIL len5_count: got %0d want 3", wr_cyc.size()); end
    for (int i = 0; i < exp_wr.size() && i < wr_cyc.size(); i++) begin
      n_tests++;
      if (wr_cyc[i] != exp_wr[i] || wr_addr[i] !== AW'(2 * i) || wr_data[i] !== sent[i]) begin
        n_fail++;
        $display("FAIL len5_wr%0d: got cyc %0d addr %0h data %0h want cyc %0d addr %0h data %0h",
                 i, wr_cyc[i], wr_addr[i], wr_data[i], exp_wr[i], 2 * i, sent[i]);
      end
    end
  endtask

  task automatic test_reset_midway();
    int r;
    clear_pats();
    load_words(4);
    model(8);
    r = exp_wr[1] + 1;
    reset_at = r;
    run_transfer(8'h5A, AW'(8));
    n_tests++;
    if (wr_cyc.size() != 2 || done_cyc.size() != 0) begin
      n_fail++; $display("FAIL rst_mid_counts: got %0d writes %0d done want 2 0", wr_cyc.size(), done_cyc.size());
    end
    n_tests++;
    if ({dl_log[r+1], busy_log[r+1], done_log[r+1], ready_log[r+1], wr_log[r+1]} !== 5'b0 ||
        addr_log[r+1] !== '0 || dout_log[r+1] !== '0 || idx_log[r+1] !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got dl %b busy %b addr %0h dout %0h idx %0h want all 0",
               dl_log[r+1], busy_log[r+1], addr_log[r+1], dout_log[r+1], idx_log[r+1]);
    end
    clear_pats();
    load_words(2);
    model(4);
    run_transfer(8'h3C, AW'(4));
    n_tests++;
    if (wr_cyc.size() != 2) begin n_fail++; $display("FAIL rst_after_count: got %0d want 2", wr_cyc.size()); end
    for (int i = 0; i < exp_wr.size() && i < wr_cyc.size(); i++) begin
      n_tests++;
      if (wr_cyc[i] != exp_wr[i] || wr_addr[i] !== AW'(2 * i) || wr_data[i] !== sent[i]) begin
        n_fail++;
        $display("FAIL rst_after_wr%0d: got cyc %0d addr %0h data %0h want cyc %0d addr %0h data %0h",
                 i, wr_cyc[i], wr_addr[i], wr_data[i], exp_wr[i], 2 * i, sent[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int bad;
    clear_pats();
    load_words(3);
    restart_at = 5;
    restart_index = 8'hEE;
    restart_length = AW'(40);
    model(6);
    run_transfer(8'h42, AW'(6));
    bad = 0;
    for (int c = 1; c <= last_c; c++) if (idx_log[c] !== 8'h42) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL ign_index: got %0d cycles with wrong index want 0", bad); end
    n_tests++;
    if (wr_cyc.size() != 3 || done_cyc.size() != 1) begin
      n_fail++; $display("FAIL ign_length: got %0d writes %0d done want 3 1", wr_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_final_wait();
    int bad;
    int d;
    clear_pats();
    load_words(2);
    for (int c = 10; c < 16; c++) wait_pat[c] = 1'b1;
    model(4);
    run_transfer(8'h77, AW'(4));
    d = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    n_tests++;
    if (done_cyc.size() != 1 || d != 16) begin
      n_fail++; $display("FAIL fwait_done: got %0d pulses first at %0d want 1 at 16", done_cyc.size(), d);
    end
    bad = 0;
    for (int c = 0; c <= last_c; c++) if (dl_log[c] !== ((c >= 1 && c <= 16) ? 1'b1 : 1'b0)) bad++;
    n_tests++;
    if (bad != 0 || wr_cyc.size() != 2) begin
      n_fail++; $display("FAIL fwait_download: got %0d bad cycles %0d writes want 0 2", bad, wr_cyc.size());
    end
  endtask

  task automatic test_random();
    int len;
    int bad;
    int d;
    logic [7:0] idx;
    for (int k = 0; k < 6; k++) begin
      clear_pats();
      for (int c = 0; c < 300; c++) begin
        valid_pat[c] = ($urandom_range(0, 9) < 7);
        wait_pat[c]  = ($urandom_range(0, 9) < 3);
      end
      len = $urandom_range(1, 24);
      idx = 8'($urandom);
      load_words((len + 1) / 2);
      model(len);
      run_transfer(idx, AW'(len));
      n_tests++;
      if (wr_cyc.size() != exp_wr.size() || viol != 0) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d writes viol %0d want %0d 0", k, wr_cyc.size(), viol, exp_wr.size());
      end
      bad = 0;
      for (int i = 0; i < exp_wr.size() && i < wr_cyc.size(); i++)
        if (wr_cyc[i] != exp_wr[i] || wr_addr[i] !== AW'(2 * i) || wr_data[i] !== sent[i] || idx_log[wr_cyc[i]] !== idx) bad++;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL rand%0d_writes: got %0d wrong writes want 0 (len %0d)", k, bad, len); end
      d = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      bad = 0;
      for (int c = 0; c <= last_c; c++) if (dl_log[c] !== ((c >= 1 && c <= exp_done) ? 1'b1 : 1'b0)) bad++;
      n_tests++;
      if (done_cyc.size() != 1 || d != exp_done || bad != 0) begin
        n_fail++; $display("FAIL rand%0d_done: got done %0d span errs %0d want done %0d errs 0", k, d, bad, exp_done);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_starvation();
    test_edge_lengths();
    test_reset_midway();
    test_ignored_start();
    test_final_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
